// File: rtl/hps_ext_pkg.sv
// hps_ext_pkg
//   Shared definitions for the HPS extension (UIO) bus host:
//   - UIO command word constants understood by hps_ext-style responders
//   - EXT_BUS bit positions for wiring the host onto the 36-bit bus
//   - host FSM state encoding
//   - timer width helper
package hps_ext_pkg;

    // UIO command words (strobe 0 of a frame)
    localparam logic [15:0] UIO_MOUSE     = 16'h0004;
    localparam logic [15:0] UIO_KEYBOARD  = 16'h0005;
    localparam logic [15:0] UIO_KBD_OSD   = 16'h0006;
    localparam logic [15:0] UIO_GET_VMODE = 16'h002C;
    localparam logic [15:0] UIO_SET_VPOS  = 16'h002D;
    localparam logic [15:0] UIO_EXT_61    = 16'h0061;
    localparam logic [15:0] UIO_EXT_62    = 16'h0062;
    localparam logic [15:0] UIO_EXT_63    = 16'h0063;

    // EXT_BUS bit positions
    localparam int EXT_DOUT_LSB = 0;   // [15:0]  responder -> host
    localparam int EXT_DIN_LSB  = 16;  // [31:16] host -> responder
    localparam int EXT_DOUT_EN  = 32;
    localparam int EXT_STROBE   = 33;
    localparam int EXT_UIO      = 34;
    localparam int EXT_FPGA     = 35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_WAIT,
        ST_HOLD
    } host_state_t;

    // Width needed to hold (max(a,b,c,d) - 1), never less than 1 bit.
    function automatic int tmr_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/hps_ext_host_tmr.sv
// hps_ext_host_tmr
//   Loadable down-counter with zero flag. The host loads (duration-1) when
//   entering a timed state and moves on once zero is seen, so a load of N-1
//   gives a state exactly N cycles long. Holds at zero.
// Ports:
//   clk      in  clock
//   reset_n  in  synchronous reset, active-low (count -> 0)
//   load     in  load load_val (has priority over dec)
//   load_val in  W  value to load
//   dec      in  decrement by one when non-zero
//   zero     out count is zero
module hps_ext_host_tmr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hps_ext_host.sv
// hps_ext_host
//   FPGA-side initiator for the HPS extension (UIO) bus. Issues one frame per
//   accepted command: command word on strobe 0, then cmd_len payload words
//   pulled from the wr_* stream, one per strobe. Responder dout sampled on the
//   last gap cycle after every strobe is returned on rd_*.
//
//   Optional feature macro: HPS_EXT_HOST_TIMEOUT_EN
//     defined   - a payload stall of TIMEOUT cycles aborts the frame
//                 (done and err pulse together)
//     undefined - payload stalls wait forever, err is tied low
//
// Parameters:
//   SETUP_CYC  cycles of uio high before the first strobe phase (>=1)
//   GAP_CYC    cycles after each strobe phase; dout sampled on the last (>=2)
//   HOLD_CYC   cycles of uio low after a frame (>=1)
//   TIMEOUT    payload stall limit in cycles (timeout build only, >=1)
// Ports:
//   clk_sys, reset_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready         frame request handshake (ready only in IDLE)
//   cmd_word[15:0], cmd_len[4:0] command word and payload word count
//   wr_valid/wr_ready, wr_data  payload stream; wr_ready pulses the cycle
//                               after a word was taken
//   rd_valid, rd_data, rd_idx   captured response and its strobe index
//   done, err                   frame end pulse, abort flag valid with done
//   io_uio, io_strobe, io_fpga, io_din[15:0]   bus outputs
//   io_dout[15:0], io_dout_en                  bus inputs
//
// Timing of one strobe: the STROBE state is a one-cycle set-up phase in
// which io_din already carries the new word; io_strobe is registered out of
// it and so is high in the first GAP cycle. io_din therefore holds its value
// the cycle before, during and after the strobe, and the responder gets
// GAP_CYC-1 cycles to present dout before it is sampled.
module hps_ext_host
    import hps_ext_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 3,
    parameter int HOLD_CYC  = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic [4:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [4:0]  rd_idx,
    output logic        done,
    output logic        err,
    output logic        io_uio,
    output logic        io_strobe,
    output logic        io_fpga,
    output logic [15:0] io_din,
    input  logic [15:0] io_dout,
    input  logic        io_dout_en
);

    localparam int TMR_W = tmr_width(SETUP_CYC, GAP_CYC, HOLD_CYC, TIMEOUT);

    host_state_t      state;
    logic [4:0]       len_q;
    logic [4:0]       idx;

    logic             accept;
    logic             last_strobe;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    assign accept      = cmd_valid && cmd_ready;
    // idx only advances while below len_q (<=31), so it saturates at 31
    assign last_strobe = (idx == len_q);
    assign io_fpga     = 1'b0;

    // Timer control: load (duration-1) on entry to a timed state, count down
    // while in it. The same counter doubles as the payload stall counter.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: tmr_dec = !tmr_zero;
            ST_STROBE: begin
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(GAP_CYC - 1);
            end
            ST_GAP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (last_strobe) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC - 1);
                end else if (!wr_valid) begin
                    // entering WAIT: stall count restarts for every payload word
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT - 1);
                end
            end
            ST_WAIT: begin
`ifdef HPS_EXT_HOST_TIMEOUT_EN
                if (!wr_valid) begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(HOLD_CYC - 1);
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
`endif
            end
            ST_HOLD: tmr_dec = !tmr_zero;
            default: ;
        endcase
    end

    hps_ext_host_tmr #(.W(TMR_W)) u_tmr (
        .clk      (clk_sys),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

`ifdef HPS_EXT_HOST_TIMEOUT_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_idx    <= '0;
            done      <= 1'b0;
            io_uio    <= 1'b0;
            io_strobe <= 1'b0;
            io_din    <= '0;
            len_q     <= '0;
            idx       <= '0;
`ifdef HPS_EXT_HOST_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            // single-cycle pulses
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            io_strobe <= 1'b0;
`ifdef HPS_EXT_HOST_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        len_q     <= cmd_len;
                        idx       <= '0;
                        io_uio    <= 1'b1;
                        io_din    <= cmd_word;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) state <= ST_STROBE;
                end
                ST_STROBE: begin
                    io_strobe <= 1'b1;
                    state     <= ST_GAP;
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        rd_valid <= io_dout_en;
                        rd_idx   <= idx;
                        if (io_dout_en) rd_data <= io_dout;
                        if (last_strobe) begin
                            state  <= ST_HOLD;
                            io_uio <= 1'b0;
                            io_din <= '0;
                            done   <= 1'b1;
                        end else if (wr_valid) begin
                            wr_ready <= 1'b1;
                            io_din   <= wr_data;
                            idx      <= idx + 5'd1;
                            state    <= ST_STROBE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wr_valid) begin
                        wr_ready <= 1'b1;
                        io_din   <= wr_data;
                        idx      <= idx + 5'd1;
                        state    <= ST_STROBE;
                    end
`ifdef HPS_EXT_HOST_TIMEOUT_EN
                    else if (tmr_zero) begin
                        state  <= ST_HOLD;
                        io_uio <= 1'b0;
                        io_din <= '0;
                        done   <= 1'b1;
                        err_q  <= 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_ext_host.sv
// tb_hps_ext_host
//   Scoreboard bench for hps_ext_host. A small behavioural responder echoes
//   UIO_GET_VMODE frames (dout = 'hA500 + strobe index); other commands are
//   write-only. Expected strobe words and read responses are queued when a
//   frame is started and popped as the DUT produces strobes / rd_valid.
//   Honours HPS_EXT_HOST_TIMEOUT_EN (TIMEOUT = 8 in that build).
module tb_hps_ext_host;
    import hps_ext_pkg::*;

    localparam int SETUP = 2;
    localparam int GAP   = 3;
    localparam int HOLD  = 2;
`ifdef HPS_EXT_HOST_TIMEOUT_EN
    localparam int TMO   = 8;
`else
    localparam int TMO   = 255;
`endif
    localparam int LIM   = 2000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_word = '0;
    logic [4:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [4:0]  rd_idx;
    logic        done;
    logic        err;
    logic        io_uio;
    logic        io_strobe;
    logic        io_fpga;
    logic [15:0] io_din;
    logic [15:0] io_dout = '0;
    logic        io_dout_en = 1'b0;

    hps_ext_host #(
        .SETUP_CYC (SETUP),
        .GAP_CYC   (GAP),
        .HOLD_CYC  (HOLD),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_word   (cmd_word),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .done       (done),
        .err        (err),
        .io_uio     (io_uio),
        .io_strobe  (io_strobe),
        .io_fpga    (io_fpga),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .io_dout_en (io_dout_en)
    );

    always #5 clk_sys = ~clk_sys;

    // behavioural responder
    logic [7:0]  rsp_cnt = '0;
    logic [15:0] rsp_cmd = '0;
    always @(posedge clk_sys) begin
        if (!io_uio) begin
            rsp_cnt    <= '0;
            io_dout_en <= 1'b0;
        end else if (io_strobe) begin
            rsp_cnt <= rsp_cnt + 8'd1;
            if (rsp_cnt == 8'd0) rsp_cmd <= io_din;
            if (((rsp_cnt == 8'd0) ? io_din : rsp_cmd) == UIO_GET_VMODE) begin
                io_dout_en <= 1'b1;
                io_dout    <= 16'hA500 + {8'h00, rsp_cnt};
            end else begin
                io_dout_en <= 1'b0;
            end
        end
    end

    // scoreboard / monitor state (all owned by the single initial process)
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_din[$];
    logic [20:0] exp_rd[$];
    logic [15:0] pay_q[$];
    int n_strb, n_wrr, n_done, n_doneerr, n_rd, n_stall_strb, n_stall_uio;
    int pop_n, stall_at = -1, stall_left = 0;
    logic        in_stall = 1'b0;
    logic [15:0] prev_din = '0;
    logic        din_bad = 1'b0;
    logic        err_seen = 1'b0;
    int          lat, w;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input int n);
        return SETUP + (n + 1) * (1 + GAP) + 1;
    endfunction

    // advance one cycle: sample outputs at negedge, then drive payload stream
    task automatic step();
        @(negedge clk_sys);
        if (io_strobe) begin
            n_strb++;
            if (in_stall) n_stall_strb++;
            chk("din_stable", io_din, prev_din);
            chk("din_q", exp_din.size(), (exp_din.size() > 0) ? exp_din.size() : 1);
            if (exp_din.size() > 0) chk("din", io_din, exp_din.pop_front());
        end
        if (rd_valid) begin
            n_rd++;
            chk("rd_q", exp_rd.size(), (exp_rd.size() > 0) ? exp_rd.size() : 1);
            if (exp_rd.size() > 0) chk("rd", {rd_idx, rd_data}, exp_rd.pop_front());
        end
        if (done) begin
            n_done++;
            if (err) n_doneerr++;
        end
        if (err) err_seen = 1'b1;
        if (wr_ready) n_wrr++;
        if (!io_uio && io_din != 16'h0) din_bad = 1'b1;
        if (in_stall && !io_uio) n_stall_uio++;
        prev_din = io_din;
        // payload producer: advance when the host reports a word consumed
        if (wr_ready) begin
            if (pay_q.size() > 0) void'(pay_q.pop_front());
            pop_n++;
        end
        if (pop_n == stall_at && stall_left > 0) begin
            stall_left--;
            in_stall = 1'b1;
        end else begin
            in_stall = 1'b0;
        end
        wr_valid = (pay_q.size() > 0) && !in_stall;
        wr_data  = (pay_q.size() > 0) ? pay_q[0] : 16'h0;
    endtask

    // caller fills pay_q first; leaves time at negedge of the cycle after accept
    task automatic start_frame(input logic [15:0] cmd, input int len);
        exp_din.delete();
        exp_rd.delete();
        exp_din.push_back(cmd);
        foreach (pay_q[i]) exp_din.push_back(pay_q[i]);
        if (cmd == UIO_GET_VMODE)
            for (int i = 0; i <= len; i++) exp_rd.push_back({5'(i), 16'hA500 + 16'(i)});
        n_strb = 0; n_wrr = 0; n_done = 0; n_doneerr = 0; n_rd = 0;
        n_stall_strb = 0; n_stall_uio = 0; pop_n = 0;
        w = 0;
        while (!cmd_ready && w < 50) begin step(); w++; end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_word  = cmd;
        cmd_len   = 5'(len);
        step();
        cmd_valid = 1'b0;
    endtask

    // lat = cycles from the accept cycle to the cycle showing done
    task automatic wait_done(output int l, input bit poke);
        l = 1;
        while (n_done == 0 && l < LIM) begin
            step();
            l++;
            if (poke && l == 3) begin cmd_valid = 1'b1; cmd_word = 16'hDEAD; cmd_len = 5'd3; end
            if (poke && l == 5) cmd_valid = 1'b0;
        end
        chk("done_seen", n_done, 1);
    endtask

    task automatic finish_frame(input int len, input int nrd);
        repeat (HOLD + 2) step();
        chk("strobes", n_strb, len + 1);
        chk("wr_ready_cnt", n_wrr, len);
        chk("done_cnt", n_done, 1);
        chk("done_err", n_doneerr, 0);
        chk("rd_cnt", n_rd, nrd);
        chk("din_left", exp_din.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
        chk("uio_idle", io_uio, 0);
        chk("ready_idle", cmd_ready, 1);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_outs", {wr_ready, rd_valid, done, err, io_uio, io_strobe, io_fpga}, 7'b0);
        chk("rst_din", io_din, 16'h0);
        chk("rst_rd", {rd_idx, rd_data}, 21'h0);
        reset_n = 1'b1;
        step();
        chk("ready_after_rst", cmd_ready, 1);

        // keyboard frame, one payload word, write-only
        pay_q.push_back(16'h001C);
        start_frame(UIO_KEYBOARD, 1);
        wait_done(lat, 1'b0);
        chk("lat_kbd", lat, exp_lat(1));
        finish_frame(1, 0);

        // get-vmode: 7 zero payloads, responses for idx 0..7
        repeat (7) pay_q.push_back(16'h0000);
        start_frame(UIO_GET_VMODE, 7);
        wait_done(lat, 1'b0);
        chk("lat_vmode", lat, exp_lat(7));
        finish_frame(7, 8);

        // set-vpos with a 20-cycle stall before payload word 2
        pay_q.push_back(16'h0010); pay_q.push_back(16'h0020);
        pay_q.push_back(16'h0030); pay_q.push_back(16'h0040);
        stall_at = 1; stall_left = 20;
        start_frame(UIO_SET_VPOS, 4);
        wait_done(lat, 1'b0);
        chk("stall_strobes", n_stall_strb, 1);
        chk("stall_uio_low", n_stall_uio, 0);
        finish_frame(4, 0);
        stall_at = -1;

        // zero-length frame; cmd_valid pulsed while busy must be ignored
        start_frame(UIO_EXT_61, 0);
        wait_done(lat, 1'b1);
        chk("lat_len0", lat, SETUP + GAP + 2);
        finish_frame(0, 0);

        // max length: 32 strobes, idx runs 0..31
        repeat (31) pay_q.push_back(16'h0000);
        start_frame(UIO_GET_VMODE, 31);
        wait_done(lat, 1'b0);
        chk("lat_len31", lat, exp_lat(31));
        finish_frame(31, 32);

        // reset during GAP of strobe 3
        repeat (5) pay_q.push_back(16'h0000);
        start_frame(UIO_GET_VMODE, 5);
        w = 0;
        while (n_strb < 3 && w < 200) begin step(); w++; end
        chk("reach_strobe3", n_strb, 3);
        step();
        reset_n = 1'b0;
        step();
        chk("midrst_uio", io_uio, 0);
        chk("midrst_strobe", io_strobe, 0);
        chk("midrst_ready", cmd_ready, 0);
        reset_n = 1'b1;
        pay_q.delete();
        step();
        chk("midrst_ready_rel", cmd_ready, 1);
        repeat (10) step();
        chk("midrst_no_done", n_done, 0);
        chk("midrst_uio_idle", io_uio, 0);

        // payload never arrives
        start_frame(UIO_SET_VPOS, 2);
`ifdef HPS_EXT_HOST_TIMEOUT_EN
        wait_done(lat, 1'b0);
        chk("lat_timeout", lat, SETUP + (1 + GAP) + TMO + 1);
        chk("timeout_err", n_doneerr, 1);
        step();
        chk("timeout_uio", io_uio, 0);
        chk("timeout_strobes", n_strb, 1);
        chk("timeout_wr", n_wrr, 0);
`else
        repeat (300) step();
        chk("stall_no_done", n_done, 0);
        chk("stall_uio_hi", io_uio, 1);
        chk("stall_strobes", n_strb, 1);
        chk("stall_busy", cmd_ready, 0);
        reset_n = 1'b0;
        step();
        chk("stall_rst_uio", io_uio, 0);
        reset_n = 1'b1;
        step();
        chk("stall_rst_ready", cmd_ready, 1);
        chk("err_tied0", err_seen, 0);
`endif
        chk("din_zero_idle", din_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
